// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl codes, BIST state encoding and LFSR constants.
// Used by the ALU, the decoder and the ALU built-in self-test.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam int          LFSR_WIDTH = 32;
    localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_e;

    // Right-shifting Galois step: the bit shifted out folds the polynomial back in.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s);
        lfsr_step = (s >> 1) ^ (s[0] ? LFSR_POLY : '0);
    endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden ALU: expected result and Zero flag for one (a, b, control) triple.
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       control,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    always_comb begin
        result = '0;
        case (control)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLT: result = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_bist.sv
// ALU built-in self-test sequencer: drives every op over NUM_VECTORS operand pairs and
// compares the ALU against alu_ref_model. Optional build macro: ALU_BIST_STOP_ON_FAIL_EN.
//
// state    | meaning
// ST_IDLE  | out of reset, outputs held, waiting for start
// ST_DRIVE | operands/control registered onto the ALU inputs
// ST_CHECK | ALU result sampled and compared, advance op/vector
// ST_DONE  | run finished, done/pass/fail_count/err_* held until next start
module alu_bist
    import alu_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter int          NUM_VECTORS = 16,
    parameter logic [31:0] SEED        = 32'hACE1_2024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic [WIDTH-1:0] alu_src_a,
    output logic [WIDTH-1:0] alu_src_b,
    output logic [2:0]       alu_control,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      fail_count,
    output logic [2:0]       err_op,
    output logic [WIDTH-1:0] err_a,
    output logic [WIDTH-1:0] err_b
);

    localparam int            VW       = (NUM_VECTORS > 2) ? $clog2(NUM_VECTORS) : 1;
    localparam logic [VW-1:0] LAST_VEC = VW'(NUM_VECTORS - 1);

    bist_state_e               state_q, state_d;
    logic [VW-1:0]             vec_q, vec_d;
    logic [LFSR_WIDTH-1:0]     lfsr_q, lfsr_d;
    logic [LFSR_WIDTH-1:0]     lfsr_b;
    logic [WIDTH-1:0]          src_a_q, src_a_d, src_b_q, src_b_d;
    logic [2:0]                ctrl_q, ctrl_d;
    logic                      done_q, done_d, pass_q, pass_d;
    logic [15:0]               fail_q, fail_d;
    logic [2:0]                err_op_q, err_op_d;
    logic [WIDTH-1:0]          err_a_q, err_a_d, err_b_q, err_b_d;
    logic                      err_seen_q, err_seen_d;
    logic [WIDTH-1:0]          exp_result;
    logic                      exp_zero;
    logic                      mismatch;
    logic                      stop_now;

    alu_ref_model #(.WIDTH(WIDTH)) u_ref (
        .a       (src_a_q),
        .b       (src_b_q),
        .control (ctrl_q),
        .result  (exp_result),
        .zero    (exp_zero)
    );

    // B of a random vector is the LFSR value one step after A.
    assign lfsr_b   = lfsr_step(lfsr_q);
    assign mismatch = (alu_result != exp_result) || (alu_zero != exp_zero);

`ifdef ALU_BIST_STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            vec_q      <= '0;
            lfsr_q     <= SEED;
            src_a_q    <= '0;
            src_b_q    <= '0;
            ctrl_q     <= ALU_ADD;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= '0;
            err_op_q   <= '0;
            err_a_q    <= '0;
            err_b_q    <= '0;
            err_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            lfsr_q     <= lfsr_d;
            src_a_q    <= src_a_d;
            src_b_q    <= src_b_d;
            ctrl_q     <= ctrl_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            err_op_q   <= err_op_d;
            err_a_q    <= err_a_d;
            err_b_q    <= err_b_d;
            err_seen_q <= err_seen_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        lfsr_d     = lfsr_q;
        src_a_d    = src_a_q;
        src_b_d    = src_b_q;
        ctrl_d     = ctrl_q;
        done_d     = done_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        err_op_d   = err_op_q;
        err_a_d    = err_a_q;
        err_b_d    = err_b_q;
        err_seen_d = err_seen_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_DRIVE;
                    vec_d      = '0;
                    lfsr_d     = SEED;
                    src_a_d    = WIDTH'(10);
                    src_b_d    = WIDTH'(20);
                    ctrl_d     = ALU_ADD;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    fail_d     = '0;
                    err_op_d   = '0;
                    err_a_d    = '0;
                    err_b_d    = '0;
                    err_seen_d = 1'b0;
                end
            end
            ST_DRIVE: state_d = ST_CHECK;
            ST_CHECK: begin
                state_d = ST_DRIVE;
                if (mismatch) begin
                    fail_d = (fail_q == 16'hFFFF) ? fail_q : fail_q + 16'd1;
                    if (!err_seen_q) begin
                        err_op_d   = ctrl_q;
                        err_a_d    = src_a_q;
                        err_b_d    = src_b_q;
                        err_seen_d = 1'b1;
                    end
                end
                if (stop_now || (ctrl_q == ALU_SLT && vec_q == LAST_VEC)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = (fail_d == '0);
                end else if (ctrl_q == ALU_SLT) begin
                    ctrl_d = ALU_ADD;
                    vec_d  = vec_q + VW'(1);
                    if (vec_q == '0) begin
                        src_a_d = WIDTH'(10);
                        src_b_d = WIDTH'(10);
                    end else begin
                        src_a_d = lfsr_q[WIDTH-1:0];
                        src_b_d = lfsr_b[WIDTH-1:0];
                        lfsr_d  = lfsr_step(lfsr_b);
                    end
                end else begin
                    ctrl_d = ctrl_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign alu_src_a   = src_a_q;
    assign alu_src_b   = src_b_q;
    assign alu_control = ctrl_q;
    assign busy        = (state_q == ST_DRIVE) || (state_q == ST_CHECK);
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_count  = fail_q;
    assign err_op      = err_op_q;
    assign err_a       = err_a_q;
    assign err_b       = err_b_q;

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist: two instances (2 and 16 vectors) each driving a bench-side
// ALU with selectable faults (0 good, 1 AND/OR swapped, 2 Zero stuck at 0).
module tb_alu_bist;

    logic        clk = 1'b0;
    logic        reset;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    // DUT with NUM_VECTORS=2
    logic        start2;
    int          mode2;
    logic [31:0] a2, b2, res2, ea2, eb2;
    logic [2:0]  c2, eop2;
    logic        z2, busy2, done2, pass2;
    logic [15:0] fail2;

    // DUT with NUM_VECTORS=16
    logic        start16;
    logic [31:0] a16, b16, res16, ea16, eb16;
    logic [2:0]  c16, eop16;
    logic        z16, busy16, done16, pass16;
    logic [15:0] fail16;

    function automatic logic [32:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] c, input int mode);
        logic [31:0] r;
        logic        z;
        case (c)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = (mode == 1) ? (a | b) : (a & b);
            3'd3: r = (mode == 1) ? (a & b) : (a | b);
            3'd4: r = a ^ b;
            3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        z = (r == 32'd0);
        if (mode == 2) z = 1'b0;
        return {z, r};
    endfunction

    always_comb {z2, res2}   = alu_fn(a2, b2, c2, mode2);
    always_comb {z16, res16} = alu_fn(a16, b16, c16, 0);

    alu_bist #(.WIDTH(32), .NUM_VECTORS(2), .SEED(32'hACE1_2024)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .alu_result(res2), .alu_zero(z2),
        .alu_src_a(a2), .alu_src_b(b2), .alu_control(c2),
        .busy(busy2), .done(done2), .pass(pass2), .fail_count(fail2),
        .err_op(eop2), .err_a(ea2), .err_b(eb2)
    );

    alu_bist #(.WIDTH(32), .NUM_VECTORS(16), .SEED(32'hACE1_2024)) u_dut16 (
        .clk(clk), .reset(reset), .start(start16),
        .alu_result(res16), .alu_zero(z16),
        .alu_src_a(a16), .alu_src_b(b16), .alu_control(c16),
        .busy(busy16), .done(done16), .pass(pass16), .fail_count(fail16),
        .err_op(eop16), .err_a(ea16), .err_b(eb16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs dut2 to done; optionally re-pulses start mid-run, which must be ignored.
    task automatic run2(input int mode, input bit poke, output int cyc);
        mode2  = mode;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        cyc    = 0;
        while (!done2 && cyc < 200) begin
            if (poke && cyc == 3) start2 = 1'b1;
            tick();
            start2 = 1'b0;
            cyc++;
        end
    endtask

    task automatic run16(output int cyc, output int busy_cnt, output logic [31:0] a24,
                         output logic [31:0] b24, output logic [31:0] a36, output logic [31:0] b36);
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        cyc      = 0;
        busy_cnt = 0;
        a24 = 'x; b24 = 'x; a36 = 'x; b36 = 'x;
        while (!done16 && cyc < 400) begin
            if (busy16) busy_cnt++;
            if (cyc == 24) begin a24 = a16; b24 = b16; end
            if (cyc == 36) begin a36 = a16; b36 = b16; end
            tick();
            cyc++;
        end
    endtask

    initial begin
        int          cyc, bc;
        logic [31:0] a24, b24, a36, b36;
        logic [31:0] exp_res [6];
        exp_res = '{32'd30, 32'hFFFF_FFF6, 32'd0, 32'd30, 32'd30, 32'd1};

        reset   = 1'b1;
        start2  = 1'b0;
        start16 = 1'b0;
        mode2   = 0;
        tick();
        tick();
        chk("rst_a",    a2, 32'd0);
        chk("rst_b",    b2, 32'd0);
        chk("rst_ctrl", {29'd0, c2}, 32'd0);
        chk("rst_busy", {31'd0, busy2}, 32'd0);
        chk("rst_done", {31'd0, done2}, 32'd0);
        chk("rst_pass", {31'd0, pass2}, 32'd0);
        chk("rst_fail", {16'd0, fail2}, 32'd0);
        chk("rst_err",  {29'd0, eop2} | ea2 | eb2, 32'd0);
        reset = 1'b0;
        tick();

        // Good ALU, 2 vectors: walk vec0 op by op
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int op = 0; op < 6; op++) begin
            chk($sformatf("v0_ctrl_op%0d", op), {29'd0, c2}, op);
            chk($sformatf("v0_a_op%0d", op), a2, 32'd10);
            chk($sformatf("v0_b_op%0d", op), b2, 32'd20);
            chk($sformatf("v0_res_op%0d", op), res2, exp_res[op]);
            chk($sformatf("v0_busy_op%0d", op), {31'd0, busy2}, 32'd1);
            tick();
            tick();
        end
        chk("v1_a", a2, 32'd10);
        chk("v1_b", b2, 32'd10);
        cyc = 12;
        while (!done2 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("good2_latency", cyc, 24);
        chk("good2_pass", {31'd0, pass2}, 32'd1);
        chk("good2_fail", {16'd0, fail2}, 32'd0);
        chk("good2_busy", {31'd0, busy2}, 32'd0);

        // AND/OR swapped, with an ignored start while busy
        run2(1, 1'b1, cyc);
`ifdef ALU_BIST_STOP_ON_FAIL_EN
        chk("swap_latency", cyc, 6);
        chk("swap_fail", {16'd0, fail2}, 32'd1);
`else
        chk("swap_latency", cyc, 24);
        chk("swap_fail", {16'd0, fail2}, 32'd2);
`endif
        chk("swap_err_op", {29'd0, eop2}, 32'd2);
        chk("swap_err_a", ea2, 32'd10);
        chk("swap_err_b", eb2, 32'd20);
        chk("swap_pass", {31'd0, pass2}, 32'd0);

        // Zero stuck at 0
        run2(2, 1'b0, cyc);
`ifdef ALU_BIST_STOP_ON_FAIL_EN
        chk("z0_latency", cyc, 6);
        chk("z0_fail", {16'd0, fail2}, 32'd1);
`else
        chk("z0_latency", cyc, 24);
        chk("z0_fail", {16'd0, fail2}, 32'd4);
`endif
        chk("z0_err_op", {29'd0, eop2}, 32'd2);
        chk("z0_err_a", ea2, 32'd10);
        chk("z0_pass", {31'd0, pass2}, 32'd0);

        // Good ALU, 16 vectors: latency, busy width, LFSR-derived operands
        run16(cyc, bc, a24, b24, a36, b36);
        chk("good16_latency", cyc, 192);
        chk("good16_busy_cycles", bc, 192);
        chk("good16_pass", {31'd0, pass16}, 32'd1);
        chk("good16_fail", {16'd0, fail16}, 32'd0);
        chk("vec2_a", a24, 32'hACE1_2024);
        chk("vec2_b", b24, 32'h5670_9012);
        chk("vec3_a", a36, 32'h2B38_4809);
        chk("vec3_b", b36, 32'h95BC_2407);

        // Reset 50 cycles into a run aborts everything
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        repeat (50) tick();
        chk("mid_busy_before", {31'd0, busy16}, 32'd1);
        reset = 1'b1;
        tick();
        chk("abort_busy", {31'd0, busy16}, 32'd0);
        chk("abort_done", {31'd0, done16}, 32'd0);
        chk("abort_pass", {31'd0, pass16}, 32'd0);
        chk("abort_fail", {16'd0, fail16}, 32'd0);
        chk("abort_ops",  a16 | b16 | {29'd0, c16}, 32'd0);
        chk("abort_err",  ea16 | eb16 | {29'd0, eop16}, 32'd0);
        reset = 1'b0;
        tick();
        run16(cyc, bc, a24, b24, a36, b36);
        chk("rerun_latency", cyc, 192);
        chk("rerun_vec2_a", a24, 32'hACE1_2024);
        chk("rerun_vec2_b", b24, 32'h5670_9012);
        chk("rerun_vec3_a", a36, 32'h2B38_4809);
        chk("rerun_pass", {31'd0, pass16}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
